// File: rtl/arbitro_transmissao_serial_if.sv
// Bus between the requesters, the serial transmitter and the arbiter.
// The arbiter uses the slave view. The requesters and the transmitter
// (or a testbench standing in for them) use the master view.
interface arbitro_transmissao_serial_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   pedido;
  logic [N*W-1:0] dados;
  logic [N-1:0]   ultimo;
  logic           pronto;
  logic [N-1:0]   aceito;
  logic           partida_serial;
  logic [W-1:0]   dados_serial;
  logic [N-1:0]   concedido;
  logic           ocupado;
  logic [3:0]     db_estado;

  modport master (
    output pedido, dados, ultimo, pronto,
    input  aceito, partida_serial, dados_serial, concedido, ocupado, db_estado
  );

  modport slave (
    input  pedido, dados, ultimo, pronto,
    output aceito, partida_serial, dados_serial, concedido, ocupado, db_estado
  );
endinterface

// File: rtl/arbitro_transmissao_serial.sv
// Frame-locked round-robin arbiter in front of a single serial transmitter.
// The owner keeps the grant until it sends a byte flagged ultimo, or until
// it stays idle in AGUARDA for TIMEOUT cycles. The round-robin pointer then
// moves to the requester after the owner.
module arbitro_transmissao_serial #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input logic                        clock,
  input logic                        reset,
  arbitro_transmissao_serial_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_FIM  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ULTIMO_IDX = IW'(N - 1);

  typedef enum logic [3:0] {
    OCIOSO   = 4'b0000,
    CARREGA  = 4'b0001,
    PARTIDA  = 4'b0010,
    ESPERA   = 4'b0011,
    FIM_BYTE = 4'b0100,
    AGUARDA  = 4'b0101
  } estado_t;

  estado_t               estado;
  logic [IW-1:0]         dono;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         escolha;
  logic [TW-1:0]         timer;
  logic                  ultimo_reg;
  logic [N-1:0][W-1:0]   byte_req;
  logic [N-1:0]          dono_oh;
  logic [N-1:0]          escolha_oh;

  // Pointer to the next requester after d, wrapping N-1 back to 0.
  function automatic logic [IW-1:0] proximo(input logic [IW-1:0] d);
    return (d == ULTIMO_IDX) ? '0 : d + IW'(1);
  endfunction

  // Per-lane unpacking of the byte bus and one-hot decodes.
  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      assign byte_req[g]   = bus.dados[g*W +: W];
      assign dono_oh[g]    = (dono == IW'(g));
      assign escolha_oh[g] = (escolha == IW'(g));
    end
  endgenerate

  // Round-robin pick: the first pending requester at or after ptr, with wrap.
  // The loop runs downward so the closest match to ptr is written last and wins.
  always_comb begin
    int j;
    j       = 0;
    escolha = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (bus.pedido[j[IW-1:0]]) escolha = j[IW-1:0];
    end
  end

  // Arbitration FSM. The outputs are registered and are set on the
  // transition into the state that owns them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado             <= OCIOSO;
      dono               <= '0;
      ptr                <= '0;
      timer              <= '0;
      ultimo_reg         <= 1'b0;
      bus.dados_serial   <= '0;
      bus.aceito         <= '0;
      bus.partida_serial <= 1'b0;
      bus.concedido      <= '0;
      bus.ocupado        <= 1'b0;
    end else begin
      bus.aceito         <= '0;
      bus.partida_serial <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (|bus.pedido) begin
            dono          <= escolha;
            bus.aceito    <= escolha_oh;
            bus.concedido <= escolha_oh;
            bus.ocupado   <= 1'b1;
            estado        <= CARREGA;
          end
        end
        CARREGA: begin
          bus.dados_serial   <= byte_req[dono];
          ultimo_reg         <= bus.ultimo[dono];
          bus.partida_serial <= 1'b1;
          estado             <= PARTIDA;
        end
        PARTIDA: estado <= ESPERA;
        ESPERA: begin
          if (bus.pronto) estado <= FIM_BYTE;
        end
        FIM_BYTE: begin
          if (ultimo_reg) begin
            ptr           <= proximo(dono);
            bus.concedido <= '0;
            bus.ocupado   <= 1'b0;
            estado        <= OCIOSO;
          end else begin
            timer  <= '0;
            estado <= AGUARDA;
          end
        end
        AGUARDA: begin
          // A request in the last timeout cycle still wins over revocation.
          if (bus.pedido[dono]) begin
            bus.aceito <= dono_oh;
            estado     <= CARREGA;
          end else if (timer == TIMER_FIM) begin
            ptr           <= proximo(dono);
            bus.concedido <= '0;
            bus.ocupado   <= 1'b0;
            estado        <= OCIOSO;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          bus.concedido <= '0;
          bus.ocupado   <= 1'b0;
          estado        <= OCIOSO;
        end
      endcase
    end
  end

  // Debug state code. Unused encodings read as 1110.
  always_comb begin
    case (estado)
      OCIOSO, CARREGA, PARTIDA, ESPERA, FIM_BYTE, AGUARDA: bus.db_estado = estado;
      default: bus.db_estado = 4'b1110;
    endcase
  end
endmodule

// File: tb/tb_arbitro_transmissao_serial.sv
// Bench for the round-robin serial arbiter. Requester queues feed a driver
// process. A transmitter process answers each start pulse with pronto.
// Expected (requester, byte) pairs are queued when stimulus is issued, and a
// monitor pops one entry on every partida_serial pulse.
module tb_arbitro_transmissao_serial;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  typedef struct packed {
    logic [7:0]   req;
    logic [W-1:0] val;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  arbitro_transmissao_serial_if #(.N(N), .W(W)) bus ();

  arbitro_transmissao_serial #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exp_t       exp_q [$];
  logic [W:0] rq [N][$];          // {ultimo, byte} per requester
  int tests    = 0;
  int fails    = 0;
  int tx_fixed = 4;               // pronto delay in ESPERA cycles; -1 = random
  int tx_spur  = 0;               // 0 none, 1 random, 2 always: pronto in PARTIDA
  bit tx_en    = 1'b1;
  int idle_req = 0;               // bump to request one pronto pulse while idle
  int ptr_m    = 0;               // reference round-robin pointer

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, want);
    end
  endtask

  task automatic carrega(input int r, input logic [W-1:0] v, input bit ult);
    rq[r].push_back({ult, v});
  endtask

  task automatic espera(input int r, input logic [W-1:0] v);
    exp_q.push_back(exp_t'{8'(r), v});
  endtask

  task automatic wait_db(input logic [3:0] code, input int lim);
    int n;
    n = 0;
    while (bus.db_estado != code && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("chega_estado_%0d", code), bus.db_estado, code);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000 && !(exp_q.size() == 0 && bus.pedido == '0 && !bus.ocupado)) begin
      @(negedge clock);
      n++;
    end
    chk("fila_esvaziada", exp_q.size(), 0);
    chk("ocupado_no_fim", bus.ocupado, 0);
    repeat (2) @(negedge clock);
  endtask

  // One random batch. Every requester in the batch gets 1..2 frames and all
  // of them raise pedido together. The reference model serves whole frames,
  // round-robin over requesters that still have frames pending.
  task automatic lote();
    logic [W:0]   pend [N][$];
    logic [W:0]   x;
    logic [W-1:0] v;
    int m, nf, nb, pick, j;
    m = $urandom_range(1, (1 << N) - 1);
    for (int r = 0; r < N; r++) begin
      if (m[r]) begin
        nf = $urandom_range(1, 2);
        for (int f = 0; f < nf; f++) begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) begin
            v = W'($urandom);
            rq[r].push_back({b == nb - 1, v});
            pend[r].push_back({b == nb - 1, v});
          end
        end
      end
    end
    forever begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        j = (ptr_m + k) % N;
        if (pick < 0 && pend[j].size() > 0) pick = j;
      end
      if (pick < 0) break;
      do begin
        x = pend[pick].pop_front();
        espera(pick, x[W-1:0]);
      end while (!x[W]);
      ptr_m = (pick + 1) % N;
    end
  endtask

  // Requester driver: raise pedido with the head byte. One cycle after
  // aceito, retire that byte and present the next one or drop pedido.
  initial begin
    logic [N-1:0] ack_prev;
    ack_prev   = '0;
    bus.pedido = '0;
    bus.dados  = '0;
    bus.ultimo = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (bus.pedido[i] && ack_prev[i]) begin
          void'(rq[i].pop_front());
          bus.pedido[i] = 1'b0;
        end
        if (!bus.pedido[i] && rq[i].size() > 0) begin
          bus.pedido[i]         = 1'b1;
          bus.dados[i*W +: W]   = rq[i][0][W-1:0];
          bus.ultimo[i]         = rq[i][0][W];
        end
      end
      ack_prev = bus.aceito;
    end
  end

  // Transmitter model: after each start pulse, wait in ESPERA, then pulse pronto.
  initial begin
    int idle_done;
    int d;
    idle_done  = 0;
    bus.pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (idle_req != idle_done) begin
        bus.pronto = 1'b1;
        @(posedge clock);
        #1;
        bus.pronto = 1'b0;
        idle_done++;
      end else if (bus.partida_serial && tx_en) begin
        if (tx_spur == 2 || (tx_spur == 1 && $urandom_range(0, 2) == 0)) bus.pronto = 1'b1;
        @(posedge clock);
        #1;
        bus.pronto = 1'b0;
        d = (tx_fixed >= 0) ? tx_fixed : $urandom_range(0, 4);
        repeat (d) begin
          @(posedge clock);
          #1;
        end
        bus.pronto = 1'b1;
        chk("estado_no_pronto", bus.db_estado, 4'd3);
        @(posedge clock);
        #1;
        bus.pronto = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every start pulse must carry the next expected byte
  // and be issued while the expected requester holds the grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.partida_serial) begin
        chk("fila_nao_vazia", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("dados_serial", bus.dados_serial, e.val);
          chk("concedido_na_partida", bus.concedido, 32'(1) << e.req);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_aceito", bus.aceito, 0);
    chk("reset_partida", bus.partida_serial, 0);
    chk("reset_dados_serial", bus.dados_serial, 0);
    chk("reset_concedido", bus.concedido, 0);
    chk("reset_ocupado", bus.ocupado, 0);
    chk("reset_db_estado", bus.db_estado, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single byte: latency and return to OCIOSO
    carrega(0, 8'h41, 1'b1);
    espera(0, 8'h41);
    @(posedge clock); #2;
    @(posedge clock); #2;
    chk("lat_aceito", bus.aceito, 4'b0001);
    chk("lat_concedido", bus.concedido, 4'b0001);
    chk("lat_carrega", bus.db_estado, 4'd1);
    @(posedge clock); #2;
    chk("lat_partida", bus.partida_serial, 1);
    chk("lat_dados", bus.dados_serial, 8'h41);
    cnt = 0;
    while (!bus.pronto && cnt < 30) begin
      @(negedge clock);
      cnt++;
    end
    chk("pronto_visto", bus.pronto, 1);
    @(negedge clock);
    chk("fim_byte_apos_pronto", bus.db_estado, 4'd4);
    @(negedge clock);
    chk("ocioso_apos_pronto", bus.db_estado, 4'd0);
    chk("livre_apos_pronto", bus.ocupado, 0);
    chk("concedido_livre", bus.concedido, 0);
    chk("dados_serial_mantido", bus.dados_serial, 8'h41);

    // ptr is 1 now: requester 1 beats requester 0
    carrega(0, 8'h51, 1'b1);
    carrega(1, 8'h61, 1'b1);
    espera(1, 8'h61);
    espera(0, 8'h51);
    wait_idle();

    // Reset mid-transfer, then a spurious pronto while idle
    tx_en = 1'b0;
    carrega(2, 8'h77, 1'b1);
    espera(2, 8'h77);
    wait_db(4'd3, 20);
    #2 reset = 1'b0;
    #1;
    chk("rst_partida", bus.partida_serial, 0);
    chk("rst_aceito", bus.aceito, 0);
    chk("rst_concedido", bus.concedido, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_dados_serial", bus.dados_serial, 0);
    chk("rst_db_estado", bus.db_estado, 0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle_req++;
    repeat (4) @(negedge clock);
    chk("pronto_ocioso_ignorado", bus.db_estado, 0);
    chk("pronto_ocioso_ocupado", bus.ocupado, 0);
    tx_en = 1'b1;

    // Simultaneous 0101 after reset: 0 then 2, ptr -> 3
    carrega(0, 8'hC0, 1'b1);
    carrega(2, 8'hC2, 1'b1);
    espera(0, 8'hC0);
    espera(2, 8'hC2);
    wait_idle();
    // ptr == 3: requester 3 beats requester 0, then wrap
    carrega(0, 8'hD0, 1'b1);
    carrega(3, 8'hD3, 1'b1);
    espera(3, 8'hD3);
    espera(0, 8'hD0);
    wait_idle();

    // Frame lock with spurious pronto in every PARTIDA cycle
    tx_spur = 2;
    carrega(1, 8'h10, 1'b0);
    carrega(1, 8'h11, 1'b0);
    carrega(1, 8'h12, 1'b1);
    carrega(0, 8'h20, 1'b1);
    espera(1, 8'h10);
    espera(1, 8'h11);
    espera(1, 8'h12);
    espera(0, 8'h20);
    wait_idle();
    tx_spur  = 0;
    tx_fixed = 2;

    // Timeout: owner 1 idles, requester 3 takes over after TO cycles
    carrega(1, 8'hA0, 1'b0);
    carrega(3, 8'hB0, 1'b1);
    espera(1, 8'hA0);
    espera(3, 8'hB0);
    wait_db(4'd5, 60);
    cnt = 1;
    while (cnt < 40) begin
      @(negedge clock);
      if (bus.db_estado == 4'd5) cnt++;
      else break;
    end
    chk("ciclos_aguarda", cnt, TO);
    chk("revogado_ocioso", bus.db_estado, 0);
    @(negedge clock);
    chk("timeout_concedido", bus.concedido, 4'b1000);
    wait_idle();

    // Request arriving in the final timeout cycle keeps the grant
    carrega(1, 8'hA1, 1'b0);
    carrega(3, 8'hB1, 1'b1);
    espera(1, 8'hA1);
    espera(1, 8'hA2);
    espera(3, 8'hB1);
    wait_db(4'd5, 60);
    cnt = 1;
    while (cnt < 40) begin
      @(negedge clock);
      if (bus.db_estado == 4'd5) begin
        cnt++;
        if (cnt == TO - 1) carrega(1, 8'hA2, 1'b1);
      end else break;
    end
    chk("ciclos_aguarda_ultimo", cnt, TO);
    chk("mantem_carrega", bus.db_estado, 4'd1);
    chk("mantem_concedido", bus.concedido, 4'b0010);
    wait_idle();

    // Randomized batches against the frame-level reference model
    ptr_m    = 0;
    tx_fixed = -1;
    tx_spur  = 1;
    repeat (25) begin
      lote();
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
